// File: rtl/ej3_a.sv
// ej3_a: serial sequence detector (Moore) on a 1-bit input.
// Raises y for one clock after the last LEN samples of x equal PATTERN.
// Overlapping matches are reported, and no state is cleared on a match.
//
// Parameters:
//   LEN      pattern length in bits (1..16)
//   PATTERN  target sequence; MSB is the oldest bit, LSB the newest
// Ports:
//   clk    in   clock; all state updates on its rising edge
//   reset  in   synchronous, active-high reset
//   x      in   serial data, sampled on every rising edge
//   y      out  registered match flag

module ej3_a #(
    parameter int unsigned      LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    localparam int unsigned FW = $clog2(LEN + 1);
    // The oldest history bit is shifted out before it is ever compared, so
    // only the newest LEN-1 samples are stored.
    localparam int unsigned HW = (LEN > 1) ? LEN - 1 : 1;

    logic [HW-1:0]  r_hist;
    logic [FW-1:0]  r_fill;
    logic           r_y;

    logic [LEN-1:0] w_window;   // last LEN samples including the current x
    logic [HW-1:0]  w_hist_d;
    logic           w_filled;   // enough samples so far to form a full window
    logic           w_match;

    generate
        if (LEN == 1) begin : g_len1
            assign w_window = x;
            assign w_hist_d = x;
        end else if (LEN == 2) begin : g_len2
            assign w_window = {r_hist, x};
            assign w_hist_d = x;
        end else begin : g_lenn
            assign w_window = {r_hist, x};
            assign w_hist_d = {r_hist[HW-2:0], x};
        end
    endgenerate

    assign w_filled = (r_fill >= FW'(LEN - 1));
    assign w_match  = w_filled && (w_window == PATTERN);

    // History shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_hist_d;
        end
    end

    // Samples-since-reset counter, saturating at LEN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= '0;
        end else if (r_fill != FW'(LEN)) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    // Registered comparator; reset wins over a match completing on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_match;
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_ej3_a.sv
// Testbench for ej3_a: two instances (PATTERN 1011 and 0000) share x/reset.
// Directed steps carry hand-derived expectations; random steps use a
// sample-history model (list of samples since reset, compare last four).
`timescale 1ns / 1ps

module tb_ej3_a;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x = 1'b1;
    logic y_a;
    logic y_b;

    int n_pass  = 0;
    int n_total = 0;

    bit q[$];   // samples accepted since the last reset, oldest first

    always #1 clk = ~clk;

    ej3_a #(.LEN(4), .PATTERN(4'b1011)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_a)
    );

    ej3_a #(.LEN(4), .PATTERN(4'b0000)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_b)
    );

    function automatic logic model_match(logic [3:0] pat);
        if (q.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q[q.size() - 1 - i] != pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: drive inputs (we are on a falling edge), take the rising
    // edge, update the model, check on the following falling edge.
    // ea/eb < 0 means "use the model" for that instance.
    task automatic cyc(input bit xv, input bit rv, input int ea, input int eb, input string tag);
        logic exp_a;
        logic exp_b;
        x     = xv;
        reset = rv;
        @(posedge clk);
        if (rv) q.delete();
        else    q.push_back(xv);
        exp_a = (ea < 0) ? model_match(4'b1011) : logic'(ea[0]);
        exp_b = (eb < 0) ? model_match(4'b0000) : logic'(eb[0]);
        @(negedge clk);
        n_total++;
        assert (y_a === exp_a) n_pass++;
        else $error("FAIL %s[1011] step %0d: y=%b expected %b", tag, n_total, y_a, exp_a);
        n_total++;
        assert (y_b === exp_b) n_pass++;
        else $error("FAIL %s[0000] step %0d: y=%b expected %b", tag, n_total, y_b, exp_b);
    endtask

    initial begin
        bit xr;
        bit rr;
        @(negedge clk);

        // Reset held two cycles with x=1
        cyc(1, 1, 0, 0, "reset");
        cyc(1, 1, 0, 0, "reset");

        // Basic match 1011
        cyc(1, 0, 0, 0, "basic");
        cyc(0, 0, 0, 0, "basic");
        cyc(1, 0, 0, 0, "basic");
        cyc(1, 0, 1, 0, "basic");
        cyc(0, 0, 0, 0, "basic_after");

        // Overlap 1011011
        cyc(0, 1, 0, 0, "ovl_rst");
        cyc(1, 0, 0, 0, "overlap");
        cyc(0, 0, 0, 0, "overlap");
        cyc(1, 0, 0, 0, "overlap");
        cyc(1, 0, 1, 0, "overlap");
        cyc(0, 0, 0, 0, "overlap");
        cyc(1, 0, 0, 0, "overlap");
        cyc(1, 0, 1, 0, "overlap");

        // Near miss 101011
        cyc(0, 1, 0, 0, "nm_rst");
        cyc(1, 0, 0, 0, "nearmiss");
        cyc(0, 0, 0, 0, "nearmiss");
        cyc(1, 0, 0, 0, "nearmiss");
        cyc(0, 0, 0, 0, "nearmiss");
        cyc(1, 0, 0, 0, "nearmiss");
        cyc(1, 0, 1, 0, "nearmiss");

        // 1111 never matches
        cyc(0, 1, 0, 0, "ones_rst");
        cyc(1, 0, 0, 0, "ones");
        cyc(1, 0, 0, 0, "ones");
        cyc(1, 0, 0, 0, "ones");
        cyc(1, 0, 0, 0, "ones");

        // Reset mid-sequence; reset on the edge that would complete 1011
        cyc(0, 1, 0, 0, "mid_rst");
        cyc(1, 0, 0, 0, "mid");
        cyc(0, 0, 0, 0, "mid");
        cyc(1, 0, 0, 0, "mid");
        cyc(1, 1, 0, 0, "mid_reset_wins");
        cyc(1, 0, 0, 0, "mid_fresh");
        cyc(0, 0, 0, 0, "mid_fresh");
        cyc(1, 0, 0, 0, "mid_fresh");
        cyc(1, 0, 1, 0, "mid_fresh");

        // Fill guard on the all-zero pattern
        cyc(1, 1, 0, 0, "fill_rst");
        cyc(0, 0, 0, 0, "fill");
        cyc(0, 0, 0, 0, "fill");
        cyc(0, 0, 0, 0, "fill");
        cyc(0, 0, 0, 1, "fill_4th");
        cyc(0, 0, 0, 1, "fill_cont");
        cyc(0, 0, 0, 1, "fill_cont");
        cyc(0, 0, 0, 1, "fill_cont");
        cyc(1, 0, 0, 0, "fill_break");

        // Random traffic against the model, occasional resets
        for (int i = 0; i < 600; i++) begin
            xr = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            if (i % 50 > 25) xr = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            rr = ($urandom_range(0, 29) == 0);
            cyc(xr, rr, -1, -1, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
